// File: rtl/decode_unit.sv
// decode_unit: second pipeline stage.
// Splits the 16-bit instruction word into fields, sign-extends immediates,
// classifies register reads/writes, tracks pending writes in a 16-entry
// scoreboard to stall read-after-write hazards, and presents one registered
// decoded instruction per cycle over a valid/ready handshake.
module decode_unit #(
  parameter int IMM_W   = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins_valid,
  input  logic [15:0]      ins,
  output logic             ins_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       op,
  output logic [3:0]       rd,
  output logic [3:0]       rs,
  output logic [3:0]       rt,
  output logic [IMM_W-1:0] imm,
  output logic             uses_rs,
  output logic             uses_rt,
  output logic             writes_rd,
  output logic             illegal,
  output logic             halted,
  input  logic             wb_valid,
  input  logic [3:0]       wb_rd
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction word fields
  logic [3:0] ins_op, ins_rd, ins_rs, ins_rt;
  assign ins_op = ins[15:12];
  assign ins_rd = ins[11:8];
  assign ins_rs = ins[7:4];
  assign ins_rt = ins[3:0];

  // Combinational decode of the incoming word
  logic             dec_uses_rs, dec_uses_rt, dec_writes_rd, dec_illegal;
  logic [IMM_W-1:0] dec_imm;

  // Registered state
  logic [15:0]      busy_q, busy_d;
  logic             halted_q;
  logic             out_valid_q;
  logic [3:0]       op_q, rd_q, rs_q, rt_q;
  logic [IMM_W-1:0] imm_q;
  logic             uses_rs_q, uses_rt_q, writes_rd_q, illegal_q;

  logic rs_conflict, rt_conflict, hazard, accept;

  // Classify the incoming opcode: reads, writes, immediate, legality
  always_comb begin
    dec_uses_rs   = 1'b0;
    dec_uses_rt   = 1'b0;
    dec_writes_rd = 1'b0;
    dec_illegal   = 1'b0;
    dec_imm       = '0;
    unique case (ins_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        dec_uses_rs   = 1'b1;
        dec_uses_rt   = 1'b1;
        dec_writes_rd = 1'b1;
      end
      OP_ADDI: begin
        dec_uses_rs   = 1'b1;
        dec_writes_rd = 1'b1;
        dec_imm       = {{(IMM_W-4){ins[3]}}, ins[3:0]};
      end
      OP_LDI: begin
        dec_writes_rd = 1'b1;
        dec_imm       = {{(IMM_W-8){ins[7]}}, ins[7:0]};
      end
      OP_LD: begin
        dec_uses_rs   = 1'b1;
        dec_writes_rd = 1'b1;
      end
      OP_ST: begin
        dec_uses_rs   = 1'b1;
        dec_uses_rt   = 1'b1;
      end
      OP_NOP, OP_HALT: begin
        dec_illegal   = 1'b0;
      end
      default: begin
        // 0x9 (reserved) and 0xA-0xD
        dec_illegal   = 1'b1;
      end
    endcase
  end

  // Read-after-write hazard against the registered scoreboard only;
  // register 0 is excluded when it is hardwired zero.
  always_comb begin
    rs_conflict = dec_uses_rs && busy_q[ins_rs] && !(R0_ZERO && (ins_rs == 4'd0));
    rt_conflict = dec_uses_rt && busy_q[ins_rt] && !(R0_ZERO && (ins_rt == 4'd0));
    hazard      = rs_conflict || rt_conflict;
  end

  assign ins_ready = !halted_q && !hazard && (!out_valid_q || out_ready);
  assign accept    = ins_valid && ins_ready;

  // Scoreboard next state: writeback clears first so a same-cycle set wins
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (accept && dec_writes_rd && !(R0_ZERO && (ins_rd == 4'd0))) begin
      busy_d[ins_rd] = 1'b1;
    end
  end

  // Scoreboard and halt flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (accept && (ins_op == OP_HALT)) begin
        halted_q <= 1'b1;
      end
    end
  end

  // Output register: load on accept, drop valid once consumed, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      uses_rs_q   <= 1'b0;
      uses_rt_q   <= 1'b0;
      writes_rd_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      op_q        <= ins_op;
      rd_q        <= ins_rd;
      rs_q        <= ins_rs;
      rt_q        <= ins_rt;
      imm_q       <= dec_imm;
      uses_rs_q   <= dec_uses_rs;
      uses_rt_q   <= dec_uses_rt;
      writes_rd_q <= dec_writes_rd;
      illegal_q   <= dec_illegal;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign op        = op_q;
  assign rd        = rd_q;
  assign rs        = rs_q;
  assign rt        = rt_q;
  assign imm       = imm_q;
  assign uses_rs   = uses_rs_q;
  assign uses_rt   = uses_rt_q;
  assign writes_rd = writes_rd_q;
  assign illegal   = illegal_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_decode_unit.sv
// Testbench for decode_unit: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_decode_unit;

  localparam int IMM_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ins_valid;
  logic [15:0]      ins;
  logic             ins_ready;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       op, rd, rs, rt;
  logic [IMM_W-1:0] imm;
  logic             uses_rs, uses_rt, writes_rd, illegal, halted;
  logic             wb_valid;
  logic [3:0]       wb_rd;

  decode_unit #(.IMM_W(IMM_W), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ins_valid(ins_valid), .ins(ins), .ins_ready(ins_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .uses_rs(uses_rs), .uses_rt(uses_rt), .writes_rd(writes_rd),
    .illegal(illegal), .halted(halted),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [15:0]  m_busy;
  bit         m_halted;
  bit         m_ov;
  bit [3:0]   m_op, m_rd, m_rs, m_rt;
  bit [15:0]  m_imm;
  bit         m_urs, m_urt, m_wr, m_ill;

  function automatic void mdec(input logic [15:0] w, output bit urs, output bit urt,
                               output bit wr, output bit ill, output bit [15:0] im);
    int o;
    int v;
    o   = int'(w[15:12]);
    urs = (o <= 5) || (o == 7) || (o == 8);
    urt = (o <= 4) || (o == 8);
    wr  = (o <= 7);
    ill = (o >= 9) && (o <= 13);
    v   = 0;
    if (o == 5) begin
      v = int'(w[3:0]);
      if (v > 7) v -= 16;
    end else if (o == 6) begin
      v = int'(w[7:0]);
      if (v > 127) v -= 256;
    end
    im = 16'(v);
  endfunction

  function automatic bit model_ready(input logic [15:0] w, input logic ordy);
    bit urs, urt, wr, ill;
    bit [15:0] im;
    bit haz;
    mdec(w, urs, urt, wr, ill, im);
    haz = (urs && w[7:4] != 0 && m_busy[w[7:4]]) || (urt && w[3:0] != 0 && m_busy[w[3:0]]);
    return !m_halted && !haz && (!m_ov || ordy);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = '0; m_halted = 0; m_ov = 0;
      m_op = 0; m_rd = 0; m_rs = 0; m_rt = 0; m_imm = 0;
      m_urs = 0; m_urt = 0; m_wr = 0; m_ill = 0;
    end else begin
      bit acc;
      bit [15:0] nb;
      acc = ins_valid && model_ready(ins, out_ready);
      nb  = m_busy;
      if (wb_valid) nb[wb_rd] = 0;
      if (acc) begin
        mdec(ins, m_urs, m_urt, m_wr, m_ill, m_imm);
        m_op = ins[15:12]; m_rd = ins[11:8]; m_rs = ins[7:4]; m_rt = ins[3:0];
        if (m_wr && m_rd != 0) nb[m_rd] = 1;
        if (m_op == 4'hF) m_halted = 1;
        m_ov = 1;
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      m_busy = nb;
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("ins_ready", ins_ready, model_ready(ins, out_ready));
      chk("out_valid", out_valid, m_ov);
      chk("halted", halted, m_halted);
      if (m_ov) begin
        chk("op", op, m_op);
        chk("rd", rd, m_rd);
        chk("rs", rs, m_rs);
        chk("rt", rt, m_rt);
        chk("imm", imm, m_imm);
        chk("uses_rs", uses_rs, m_urs);
        chk("uses_rt", uses_rt, m_urt);
        chk("writes_rd", writes_rd, m_wr);
        chk("illegal", illegal, m_ill);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [15:0] w, input logic ordy,
                       input logic wbv, input logic [3:0] wbr);
    ins_valid = v; ins = w; out_ready = ordy; wb_valid = wbv; wb_rd = wbr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int halt_cycles;
    rst_n = 1'b0;
    drive(0, 16'h0000, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_op", op, 0);
    chk("rst_imm", imm, 0);
    chk("rst_writes_rd", writes_rd, 0);
    rst_n = 1'b1;

    // ADD r0,r10,r1
    drive(1, 16'h00A1, 1, 0, 0);
    tick();
    drive(1, 16'h1100, 1, 0, 0);   // SUB r1,r0,r0: reads r0, must not stall
    #1;
    chk("add_valid", out_valid, 1);
    chk("add_op", op, 4'h0);
    chk("add_rd", rd, 4'h0);
    chk("add_rs", rs, 4'hA);
    chk("add_rt", rt, 4'h1);
    chk("add_wr", writes_rd, 1);
    chk("r0_never_busy", ins_ready, 1);
    tick();

    // LDI r15,0x80 with r1 written back in the same cycle
    drive(1, 16'h6F80, 1, 1, 4'd1);
    tick();
    chk("ldi_imm", imm, 16'hFF80);
    chk("ldi_wr", writes_rd, 1);
    chk("ldi_urs", uses_rs, 0);

    // SUB r15,r2,r15 stalls on r15 until writeback, released the cycle after
    drive(1, 16'h1F2F, 1, 0, 0);
    #1;
    chk("raw_stall0", ins_ready, 0);
    tick();
    chk("raw_stall1", ins_ready, 0);
    drive(1, 16'h1F2F, 1, 1, 4'd15);
    #1;
    chk("raw_no_bypass", ins_ready, 0);
    tick();
    drive(1, 16'h1F2F, 1, 0, 0);
    #1;
    chk("raw_released", ins_ready, 1);
    tick();
    chk("sub_op", op, 4'h1);
    chk("sub_rd", rd, 4'hF);

    // ADDI r1,r13,2 held under backpressure
    drive(1, 16'h51D2, 1, 0, 0);
    tick();
    drive(1, 16'hE000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", ins_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_op", op, 4'h5);
      chk("bp_imm", imm, 16'h0002);
      chk("bp_rs", rs, 4'hD);
      tick();
    end
    drive(1, 16'hE000, 1, 0, 0);
    #1;
    chk("bp_release", ins_ready, 1);
    tick();
    chk("nop_op", op, 4'hE);

    // Set/clear collision on r3: set wins
    drive(1, 16'h6300, 1, 0, 0);
    tick();
    drive(1, 16'h6305, 1, 1, 4'd3);
    tick();
    drive(1, 16'h0033, 1, 0, 0);
    #1;
    chk("collision_busy", ins_ready, 0);
    drive(1, 16'h0033, 1, 1, 4'd3);
    tick();
    drive(1, 16'h0033, 1, 0, 0);
    #1;
    chk("collision_cleared", ins_ready, 1);
    tick();

    // Illegal opcode
    drive(1, 16'hB123, 1, 0, 0);
    tick();
    chk("ill_flag", illegal, 1);
    chk("ill_wr", writes_rd, 0);
    chk("ill_urs", uses_rs, 0);

    // HALT
    drive(1, 16'hF000, 1, 0, 0);
    tick();
    chk("halt_op", op, 4'hF);
    chk("halt_valid", out_valid, 1);
    chk("halt_flag", halted, 1);
    drive(1, 16'hE000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_ready", ins_ready, 0);
      tick();
    end

    // Asynchronous reset mid-stall (r1, r15 busy at this point)
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_halted", halted, 0);
    rst_n = 1'b1;
    drive(1, 16'h0F1F, 1, 0, 0);
    #1;
    chk("arst_sb_clear", ins_ready, 1);
    tick();

    // Randomized traffic
    halt_cycles = 0;
    for (int n = 0; n < 4000; n++) begin
      logic [15:0] w;
      logic [3:0]  o;
      bit hold;
      hold = ins_valid && !model_ready(ins, out_ready);
      if (hold && ($urandom_range(0, 9) != 0)) begin
        w = ins;
      end else begin
        o = 4'($urandom_range(0, 15));
        if (o == 4'hF && $urandom_range(0, 7) != 0) o = 4'($urandom_range(0, 8));
        w[15:12] = o;
        w[11:8]  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        w[7:4]   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        w[3:0]   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      end
      drive(hold ? 1'b1 : 1'($urandom_range(0, 3) != 0), w,
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
      if (m_halted) halt_cycles++;
      if (halt_cycles > 6) begin
        halt_cycles = 0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      tick();
    end

    drive(0, 16'h0000, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_unit.md
Name: decode_unit

Overview:
- Second pipeline stage. Sits directly downstream of the instruction fetch stage and consumes its 16-bit instruction word.
- Splits each instruction into fields, sign-extends immediates and classifies register reads and writes.
- Tracks pending register writes in a 16-entry scoreboard and stalls read-after-write hazards.
- Presents one registered decoded instruction per cycle to the execute stage over a valid/ready handshake.

Parameters:
IMM_W, 16, width of the sign-extended immediate output (must be >= 8)
R0_ZERO, 1, when 1 register 0 is hardwired zero: never marked busy and never causes a hazard

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ins_valid  input  1  upstream instruction word valid
ins  input  16  instruction word: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt
ins_ready  output  1  decode accepts ins this cycle
out_valid  output  1  decoded instruction valid
out_ready  input  1  execute stage accepts decoded instruction
op  output  4  registered opcode
rd  output  4  destination register
rs  output  4  source register A
rt  output  4  source register B
imm  output  IMM_W  sign-extended immediate
uses_rs  output  1  instruction reads rs
uses_rt  output  1  instruction reads rt
writes_rd  output  1  instruction writes rd
illegal  output  1  opcode 0xA-0xD
halted  output  1  HALT has been accepted
wb_valid  input  1  writeback completing this cycle
wb_rd  input  4  register being written back

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, halted=0, scoreboard all 0, and op/rd/rs/rt/imm/uses_*/writes_rd/illegal all 0. ins_ready follows combinationally.
- Opcode decode:
  - 0-4 ADD/SUB/AND/OR/XOR: reads rs and rt, writes rd, imm=0.
  - 5 ADDI: reads rs, writes rd, imm=sext(ins[3:0]).
  - 6 LDI: writes rd, imm=sext(ins[7:0]).
  - 7 LD: reads rs, writes rd.
  - 8 ST: reads rs (address) and rt (data), no write.
  - 0xA-0xD: illegal=1, no reads or writes.
  - 0xE NOP: no reads or writes.
  - 0xF HALT: no reads or writes.
  - Opcode 9 is reserved and treated as illegal.
- Hazard (combinational on ins): (uses_rs(ins) && busy[ins.rs]) || (uses_rt(ins) && busy[ins.rt]). With R0_ZERO=1, register 0 never contributes.
- ins_ready = !halted && !hazard && (!out_valid || out_ready).
- Accept = ins_valid && ins_ready.
  - On accept the output register loads the decoded fields and out_valid=1 on the next edge. Latency is exactly 1 cycle.
- Output side:
  - If out_valid && out_ready and there is no accept, out_valid clears on the next edge.
  - While out_valid && !out_ready, all outputs hold stable.
  - ins_ready=0 while stalled. Fetch must hold ins.
- Scoreboard:
  - On accept with writes_rd, set busy[rd], except rd=0 when R0_ZERO=1.
  - On wb_valid, clear busy[wb_rd].
  - Same register set and cleared in the same cycle: set wins.
  - Hazard uses the registered busy only. A clear removes the stall on the following cycle, with no same-cycle bypass.
- Halt:
  - Accepting HALT forwards it downstream normally and sets halted=1 on the same edge.
  - Afterwards ins_ready=0 permanently until rst_n asserts.
  - The scoreboard still clears on writeback while halted.
- Reset mid-operation: all state clears immediately, independent of clk. The in-flight decoded instruction is dropped.
- ins_valid=0 or a stalled cycle leaves the scoreboard unchanged, apart from writeback clears.

Test Plan:
- Reset then ins=0x00A1 (ADD r0,r10,r1) valid, out_ready=1 -> next cycle out_valid=1, op=0, rd=0, rs=10, rt=1, writes_rd=1, busy[0] stays 0.
- ins=0x6F80 (LDI r15,0x80) -> imm=0xFF80, writes_rd=1, uses_rs=0. Then ins=0x1F2F (SUB r15,r2,r15) -> ins_ready=0 until wb_valid with wb_rd=15 is pulsed; ready=1 the cycle after.
- ins=0x51D2 (ADDI r1,r13,2) with out_ready=0 for 3 cycles -> out_valid stays 1, fields stable, ins_ready=0; the next word is accepted only when out_ready=1.
- Set/clear collision: busy[3]=1, accept 0x6305 while wb_valid with wb_rd=3 in the same cycle -> busy[3] remains 1.
- ins=0xB123 -> illegal=1, no scoreboard change. ins=0xF000 -> out_valid with op=0xF, halted=1, ins_ready stuck 0.
- rst_n low mid-stall -> out_valid=0, halted=0, scoreboard cleared, immediately and asynchronously.
